// File: rtl/slowfil_pkg.sv
// slowfil_pkg
// Shared definitions for the slow-FIR sequencer slice.
//  - state_t        : sequencer states (filter reset, coefficient load, run)
//  - min_spacing()  : smallest legal strobe spacing for a given tap count
//  - SPACING_MARGIN : extra idle cycles added on top of the minimum spacing
package slowfil_pkg;

  typedef enum logic [1:0] {
    S_FRST = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  localparam int SPACING_MARGIN = 1;

  // The filter needs one cycle per tap plus one to dump its result before
  // it can take another sample.
  function automatic int min_spacing(input int ntaps);
    return ntaps + 1;
  endfunction

endpackage

// File: rtl/slowfil_seq_gapctr.sv
// slowfil_seq_gapctr
// Down-counter enforcing the idle spacing between filter sample strobes.
// Ports:
//  clk    in  clock
//  reset  in  synchronous active-high reset (clears the count)
//  load   in  reload the counter with SPACING-1
//  zero   out counter has reached zero; a new strobe may be issued
module slowfil_seq_gapctr #(
  parameter int SPACING = 112
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic zero
);

  localparam int GW = $clog2(SPACING);
  localparam logic [GW-1:0] RELOAD = GW'(SPACING - 1);

  logic [GW-1:0] gap;

  // Loaded on the same edge that issues the strobe, so the strobe cycle sees
  // SPACING-1 and the counter reaches zero exactly SPACING-1 cycles later.
  always_ff @(posedge clk) begin
    if (reset) begin
      gap <= '0;
    end else if (load) begin
      gap <= RELOAD;
    end else if (gap != '0) begin
      gap <= gap - 1'b1;
    end
  end

  assign zero = (gap == '0);

endmodule

// File: rtl/slowfil_seq.sv
// slowfil_seq
// Sequencer in front of the single-multiplier slow FIR: resets the filter,
// streams NTAPS coefficients into it, admits samples over valid/ready with a
// minimum strobe spacing, and defers coefficient reloads until the running
// accumulation has finished.
// Ports:
//  i_clk, i_reset                  clock, synchronous active-high reset
//  i_load                          request coefficient (re)load
//  i_coef_valid/o_coef_ready/i_coef  coefficient handshake
//  i_valid/o_ready/i_sample        sample handshake
//  o_fil_reset                     filter reset
//  o_tap_wr/o_tap                  filter tap write strobe and value
//  o_fil_ce/o_fil_sample           filter sample strobe and value
//  o_loaded                        full coefficient set present
//  o_busy                          not running or spacing gap still open
// Optional feature macro SLOWFIL_SEQ_STATS_EN adds:
//  o_nsamples [31:0]               accepted samples (wraps)
//  o_nstall   [15:0]               run cycles with i_valid && !o_ready (saturates)
module slowfil_seq
  import slowfil_pkg::*;
#(
  parameter int LGNTAPS = 7,
  parameter int NTAPS   = 110,
  parameter int IW      = 16,
  parameter int TW      = 16,
  parameter int SPACING = min_spacing(NTAPS) + SPACING_MARGIN
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_load,
  input  logic          i_coef_valid,
  output logic          o_coef_ready,
  input  logic [TW-1:0] i_coef,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [IW-1:0] i_sample,
  output logic          o_fil_reset,
  output logic          o_tap_wr,
  output logic [TW-1:0] o_tap,
  output logic          o_fil_ce,
  output logic [IW-1:0] o_fil_sample,
  output logic          o_loaded,
  output logic          o_busy
`ifdef SLOWFIL_SEQ_STATS_EN
  ,
  output logic [31:0]   o_nsamples,
  output logic [15:0]   o_nstall
`endif
);

  localparam logic [LGNTAPS-1:0] LAST_TAP = LGNTAPS'(NTAPS - 1);

  state_t             state, state_next;
  logic [LGNTAPS-1:0] count, count_next;
  logic               load_pending, pending_next;
  logic               loaded_next;
  logic               gap_zero;
  logic               coef_fire;
  logic               sample_fire;

  slowfil_seq_gapctr #(
    .SPACING (SPACING)
  ) u_gapctr (
    .clk   (i_clk),
    .reset (i_reset),
    .load  (sample_fire),
    .zero  (gap_zero)
  );

  // Next-state and handshake decode. o_ready depends only on registers so
  // there is no combinational path from any input to it.
  always_comb begin
    state_next   = state;
    count_next   = count;
    pending_next = load_pending;
    loaded_next  = o_loaded;
    o_coef_ready = 1'b0;
    o_ready      = 1'b0;
    coef_fire    = 1'b0;
    sample_fire  = 1'b0;
    case (state)
      S_FRST: begin
        state_next = S_LOAD;
        count_next = '0;
      end
      S_LOAD: begin
        o_coef_ready = 1'b1;
        // A reload request discards the partial set, including any word
        // offered in the same cycle.
        if (i_load) begin
          state_next = S_FRST;
        end else if (i_coef_valid) begin
          coef_fire = 1'b1;
          if (count == LAST_TAP) begin
            state_next  = S_RUN;
            loaded_next = 1'b1;
          end else begin
            count_next = count + 1'b1;
          end
        end
      end
      S_RUN: begin
        o_ready     = gap_zero && !load_pending;
        sample_fire = i_valid && o_ready;
        if (i_load) begin
          pending_next = 1'b1;
        end
        // Reload only once the last accumulation has had its full spacing.
        if (gap_zero && load_pending) begin
          state_next   = S_FRST;
          pending_next = 1'b0;
          loaded_next  = 1'b0;
        end
      end
      default: begin
        state_next = S_FRST;
      end
    endcase
  end

  // Control state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= S_FRST;
      count        <= '0;
      load_pending <= 1'b0;
      o_loaded     <= 1'b0;
    end else begin
      state        <= state_next;
      count        <= count_next;
      load_pending <= pending_next;
      o_loaded     <= loaded_next;
    end
  end

  // Registered pass-through of coefficients and samples toward the filter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_tap_wr     <= 1'b0;
      o_tap        <= '0;
      o_fil_ce     <= 1'b0;
      o_fil_sample <= '0;
    end else begin
      o_tap_wr <= coef_fire;
      if (coef_fire) begin
        o_tap <= i_coef;
      end
      o_fil_ce <= sample_fire;
      if (sample_fire) begin
        o_fil_sample <= i_sample;
      end
    end
  end

  assign o_fil_reset = i_reset | (state == S_FRST);
  assign o_busy      = (state != S_RUN) || !gap_zero;

`ifdef SLOWFIL_SEQ_STATS_EN
  // Statistics restart with every new coefficient set.
  always_ff @(posedge i_clk) begin
    if (i_reset || (state_next == S_FRST)) begin
      o_nsamples <= '0;
      o_nstall   <= '0;
    end else begin
      if (sample_fire) begin
        o_nsamples <= o_nsamples + 1'b1;
      end
      if ((state == S_RUN) && i_valid && !o_ready && (o_nstall != 16'hFFFF)) begin
        o_nstall <= o_nstall + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_slowfil_seq.sv
// tb_slowfil_seq
// Directed bench for slowfil_seq with NTAPS=110, SPACING=112. Inputs are
// driven and outputs observed on the falling clock edge.
// Optional feature macro SLOWFIL_SEQ_STATS_EN enables the statistics checks.
module tb_slowfil_seq;

  localparam int NTAPS   = 110;
  localparam int SPACING = 112;

  logic        i_clk        = 1'b0;
  logic        i_reset      = 1'b1;
  logic        i_load       = 1'b0;
  logic        i_coef_valid = 1'b0;
  logic [15:0] i_coef       = '0;
  logic        i_valid      = 1'b0;
  logic [15:0] i_sample     = '0;
  logic        o_coef_ready, o_ready, o_fil_reset, o_tap_wr, o_fil_ce;
  logic        o_loaded, o_busy;
  logic [15:0] o_tap, o_fil_sample;
`ifdef SLOWFIL_SEQ_STATS_EN
  logic [31:0] o_nsamples;
  logic [15:0] o_nstall;
`endif

  int checks_total  = 0;
  int checks_passed = 0;
  int checks_failed = 0;

  slowfil_seq #(
    .LGNTAPS (7),
    .NTAPS   (NTAPS),
    .IW      (16),
    .TW      (16),
    .SPACING (SPACING)
  ) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_load       (i_load),
    .i_coef_valid (i_coef_valid),
    .o_coef_ready (o_coef_ready),
    .i_coef       (i_coef),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_sample     (i_sample),
    .o_fil_reset  (o_fil_reset),
    .o_tap_wr     (o_tap_wr),
    .o_tap        (o_tap),
    .o_fil_ce     (o_fil_ce),
    .o_fil_sample (o_fil_sample),
    .o_loaded     (o_loaded),
    .o_busy       (o_busy)
`ifdef SLOWFIL_SEQ_STATS_EN
    ,
    .o_nsamples   (o_nsamples),
    .o_nstall     (o_nstall)
`endif
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks_total++;
    assert (observed === expected) checks_passed++;
    else begin
      checks_failed++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Hold reset two cycles, check reset values, release and check the single
  // filter-reset cycle that follows; returns at a falling edge in S_LOAD.
  task automatic doReset();
    i_reset      = 1'b1;
    i_load       = 1'b0;
    i_coef_valid = 1'b0;
    i_valid      = 1'b0;
    repeat (2) @(negedge i_clk);
    checkOutput("rst_fil_reset", o_fil_reset, 1);
    checkOutput("rst_loaded", o_loaded, 0);
    checkOutput("rst_busy", o_busy, 1);
    checkOutput("rst_tap_wr", o_tap_wr, 0);
    checkOutput("rst_tap", o_tap, 0);
    checkOutput("rst_fil_ce", o_fil_ce, 0);
    checkOutput("rst_fil_sample", o_fil_sample, 0);
    checkOutput("rst_ready", o_ready, 0);
    checkOutput("rst_coef_ready", o_coef_ready, 0);
`ifdef SLOWFIL_SEQ_STATS_EN
    checkOutput("rst_nsamples", o_nsamples, 0);
    checkOutput("rst_nstall", o_nstall, 0);
`endif
    i_reset = 1'b0;
    #1;
    checkOutput("frst_after_release", o_fil_reset, 1);
    checkOutput("frst_coef_ready", o_coef_ready, 0);
    @(negedge i_clk);
    checkOutput("load_fil_reset", o_fil_reset, 0);
  endtask

  // Stream a full coefficient set base+1..base+NTAPS back-to-back, checking
  // each tap write one cycle after its handshake.
  task automatic applyStimulus(input int base);
    for (int k = 0; k <= NTAPS; k++) begin
      if (k > 0) begin
        checkOutput("load_tap_wr", o_tap_wr, 1);
        checkOutput("load_tap", o_tap, base + k);
        checkOutput("load_loaded", o_loaded, (k == NTAPS));
      end
      if (k < NTAPS) begin
        checkOutput("load_coef_ready", o_coef_ready, 1);
        checkOutput("load_ready", o_ready, 0);
        i_coef_valid = 1'b1;
        i_coef       = 16'(base + k + 1);
      end else begin
        checkOutput("run_busy", o_busy, 0);
        checkOutput("run_ready", o_ready, 1);
        checkOutput("run_coef_ready", o_coef_ready, 0);
        i_coef_valid = 1'b0;
      end
      @(negedge i_clk);
    end
    checkOutput("load_tap_wr_idle", o_tap_wr, 0);
  endtask

  initial begin
    // 1: reset and first coefficient load 0x0001..0x006E
    @(negedge i_clk);
    doReset();
    applyStimulus(0);

    // 2: three samples with i_valid held high
    for (int c = 0; c <= 225; c++) begin
      checkOutput("t2_ready", o_ready, (c % SPACING == 0));
      checkOutput("t2_fil_ce", o_fil_ce, (c % SPACING == 1));
      checkOutput("t2_busy", o_busy, (c % SPACING != 0));
      if (c % SPACING == 1) begin
        checkOutput("t2_fil_sample", o_fil_sample, c / SPACING + 1);
      end
      i_valid  = (c <= 224);
      i_sample = 16'(c / SPACING + 1);
      @(negedge i_clk);
    end
`ifdef SLOWFIL_SEQ_STATS_EN
    checkOutput("t6_nsamples", o_nsamples, 3);
    checkOutput("t6_nstall", o_nstall, 222);
`endif

    // 3: reload requested 5 cycles after the strobe at cycle 225
    for (int c = 226; c <= 337; c++) begin
      checkOutput("t3_fil_reset", o_fil_reset, (c == 337));
      checkOutput("t3_loaded", o_loaded, (c <= 336));
      checkOutput("t3_ready", o_ready, 0);
      checkOutput("t3_fil_ce", o_fil_ce, 0);
      i_load = (c == 230);
      @(negedge i_clk);
    end
    checkOutput("t3_coef_ready", o_coef_ready, 1);

    // 4: reload request on the 50th coefficient restarts the load
    for (int k = 0; k < 50; k++) begin
      if (k > 0) begin
        checkOutput("t4_tap_wr", o_tap_wr, 1);
        checkOutput("t4_tap", o_tap, 32'h100 + k);
      end
      checkOutput("t4_loaded", o_loaded, 0);
      i_coef_valid = 1'b1;
      i_coef       = 16'(32'h100 + k + 1);
      i_load       = (k == 49);
      @(negedge i_clk);
    end
    checkOutput("t4_fil_reset", o_fil_reset, 1);
    checkOutput("t4_tap_wr_dropped", o_tap_wr, 0);
    checkOutput("t4_coef_ready_frst", o_coef_ready, 0);
    checkOutput("t4_loaded_frst", o_loaded, 0);
    i_coef_valid = 1'b0;
    i_load       = 1'b0;
    @(negedge i_clk);
    checkOutput("t4_reload_ready", o_coef_ready, 1);
    checkOutput("t4_reload_fil_reset", o_fil_reset, 0);
    applyStimulus(32'h200);

    // 5: reset while the gap counter sits at 60
    for (int c = 0; c < 52; c++) begin
      if (c == 0) begin
        checkOutput("t5_ready", o_ready, 1);
      end else begin
        checkOutput("t5_ready_gap", o_ready, 0);
      end
      if (c == 1) begin
        checkOutput("t5_fil_ce", o_fil_ce, 1);
        checkOutput("t5_fil_sample", o_fil_sample, 32'h55);
      end
      i_valid  = (c == 0);
      i_sample = 16'h0055;
      @(negedge i_clk);
    end
    doReset();
    i_valid  = 1'b1;
    i_sample = 16'h0077;
    applyStimulus(32'h300);
    checkOutput("t5_fil_ce_after", o_fil_ce, 1);
    checkOutput("t5_fil_sample_after", o_fil_sample, 32'h77);
    i_valid = 1'b0;
    @(negedge i_clk);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
